// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, DEPTH-entry queue, gnt->instr_valid 2 cycles, requests gated on queue space.
// Redirects flush queue and in-flight reads; FETCH_MISALIGN_CHECK_EN parks on misaligned redirect targets.
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            fetch_misalign
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            outstanding, space, granted, push, pop;
  logic [XLEN-1:0] target_pc;
  logic            bad_target, park, park_nxt;
  state_t          resume;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign target_pc  = redirect_pc;
  assign bad_target = |redirect_pc[1:0];
  assign park       = misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          misalign_q <= 1'b0;
    else if (redirect) misalign_q <= bad_target;
  end

  assign fetch_misalign = misalign_q;
`else
  assign target_pc      = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign bad_target     = 1'b0;
  assign park           = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  assign outstanding = (state == WAIT) || (state == DROP);
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign space       = occupancy < (CW+1)'(DEPTH);

  // Where the FSM goes once nothing is in flight: parked while the target is misaligned.
  assign park_nxt = redirect ? bad_target : park;
  assign resume   = park_nxt ? IDLE : REQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = resume;
      REQ: begin
        if (granted)       state_nxt = redirect ? DROP : WAIT;
        else if (redirect) state_nxt = resume;
      end
      WAIT: begin
        if (imem_rvalid)   state_nxt = resume;
        else if (redirect) state_nxt = DROP;
      end
      // A stale response landing together with a redirect still retires the read.
      DROP: if (imem_rvalid) state_nxt = resume;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == REQ) && space;
    imem_addr = fetch_pc;
    granted   = imem_req && imem_gnt;
    push      = (state == WAIT) && imem_rvalid && !redirect;
    pop       = instr_valid && instr_ready && !redirect;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= target_pc;
    else if (granted)  fetch_pc <= fetch_pc + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= imem_rdata;
        q_pc[wr_ptr]    <= fetch_pc - XLEN'(4);
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = q_instr[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];

endmodule
